ap_ctrl_scheduler: RTL and testbench

//  Shares one HLS kernel instance (ap_ctrl_chain port set: ap_start/ap_ready/ap_done/ap_continue)

---
 rtl/ap_ctrl_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_ap_ctrl_scheduler.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_scheduler.sv
// ap_ctrl_scheduler: shares one ap_ctrl_chain HLS kernel between NUM_REQ
// requesters. Requesters are served round-robin; each grant is one kernel
// invocation. The block also counts completed invocations, records the
// latency of the last one and raises a sticky watchdog flag.
//
// Handshakes:
//   requester side : req[i] is a level request. The request is accepted on the
//                    rising edge where IDLE grants it (gnt[i] rises). gnt[i]
//                    then stays high until the invocation completes, and
//                    done_ack[i] pulses for exactly one cycle at completion.
//                    req changes after acceptance have no effect.
//   kernel side    : ap_start (valid) stays high until a cycle with ap_ready
//                    high; that cycle is the input transfer. ap_done (valid)
//                    is held by the kernel until a cycle with ap_continue high;
//                    that cycle is the output transfer.
module ap_ctrl_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done_ack,
    output logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    output logic               ap_continue,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   last_latency,
    output logic               timeout_err,
    input  logic               clr_err,
    output logic [1:0]         state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Watchdog fires when the latency counter reaches this value without ap_done.
    localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   rr_next;
    logic [CNT_W-1:0]   lat_cnt;
    logic               wdog_hit;
    int                 scan_idx;

    // Round-robin pick: first set request bit scanning from rr_ptr upwards, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign rr_next    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and kernel/requester outputs decoded from state.
    always_comb begin
        state_d     = state_q;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        busy        = 1'b1;
        done_ack    = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                ap_start = 1'b1;
                if (ap_ready && ap_done) begin
                    state_d = S_DONE;
                end else if (ap_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // ap_ready is meaningless here; only completion matters.
                if (ap_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ap_continue = 1'b1;
                done_ack    = gnt;
                state_d     = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;

    // Grant, round-robin pointer, latency counter and completion statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt          <= '0;
            rr_ptr       <= '0;
            lat_cnt      <= '0;
            txn_count    <= '0;
            last_latency <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        gnt     <= win_onehot;
                        rr_ptr  <= rr_next;
                        lat_cnt <= '0;
                    end
                end
                S_START, S_RUN: begin
                    // Saturate rather than wrap so a hung kernel never looks fast.
                    if (lat_cnt != '1) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    gnt          <= '0;
                    last_latency <= lat_cnt;
                    if (txn_count != '1) begin
                        txn_count <= txn_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wdog_hit = (TIMEOUT != 0) &&
                      ((state_q == S_START) || (state_q == S_RUN)) &&
                      (lat_cnt == LAT_LIMIT) && !ap_done;

    // Sticky watchdog flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (wdog_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_scheduler.sv
// Bench for ap_ctrl_scheduler: a reactive kernel model drives ap_ready/ap_done,
// while a round-robin model predicts grants, counts and latencies.
`timescale 1ns/1ps
module tb_ap_ctrl_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done_ack;
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic               busy;
    logic [CNT_W-1:0]   txn_count;
    logic [CNT_W-1:0]   last_latency;
    logic               timeout_err;
    logic               clr_err;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_rr  = 0;
    int m_txn = 0;
    logic [NUM_REQ-1:0] exp_q[$];

    // Invariant violation tallies gathered while driving.
    int onehot_viol = 0;
    int ack_viol    = 0;
    int gnt_move    = 0;

    // Clock / reset block.
    always #5 clock = ~clock;

    ap_ctrl_scheduler #(
        .NUM_REQ(NUM_REQ),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .done_ack    (done_ack),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .busy        (busy),
        .txn_count   (txn_count),
        .last_latency(last_latency),
        .timeout_err (timeout_err),
        .clr_err     (clr_err),
        .state_dbg   (state_dbg)
    );

    // Round-robin rule: first set bit scanning rr, rr+1, ... mod NUM_REQ.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int rr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(rr + i) % NUM_REQ]) return (rr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot_of(input int idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Driver: performs one invocation acting as the kernel. Called at a negedge
    // where the scheduler is idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic do_inv(input logic [NUM_REQ-1:0] rq, input int rdy, input int run,
                          input bit same, input bit drop,
                          output logic [NUM_REQ-1:0] g, output int st_cyc,
                          output logic [NUM_REQ-1:0] ack_val, output int acks,
                          output int conts, output bit idle_after);
        int rc;
        bit fin;
        req = rq;
        g = '0; st_cyc = 0; ack_val = '0; acks = 0; conts = 0; rc = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clock);
            if (!$onehot0(gnt)) onehot_viol++;
            if (done_ack != '0) begin
                acks++;
                ack_val = done_ack;
                if (!ap_continue || done_ack !== g) ack_viol++;
            end
            if (ap_continue) begin
                conts++;
                if (gnt !== g) gnt_move++;
                ap_done  = 1'b0;
                ap_ready = 1'b0;
                fin = 1'b1;
            end else if (ap_start) begin
                if (st_cyc == 0) g = gnt;
                else if (gnt !== g) gnt_move++;
                ap_ready = (st_cyc == rdy);
                ap_done  = same && (st_cyc == rdy);
                st_cyc++;
            end else if (busy) begin
                if (gnt !== g) gnt_move++;
                ap_ready = 1'($urandom_range(0, 1));
                if (drop) req = rq & ~g;
                if (rc == run - 1) ap_done = 1'b1;
                rc++;
            end
        end
        n_checks++;
        if (!fin) begin
            n_errors++;
            $display("FAIL inv_complete: invocation did not finish, got busy=%b exp done within 200 cycles", busy);
        end
        @(negedge clock);
        idle_after = !busy;
        if (done_ack != '0) acks++;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        req = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; ap_ready = 1'b0; ap_done = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({gnt, done_ack, ap_start, ap_continue, busy, timeout_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got gnt=%b ack=%b start=%b cont=%b busy=%b err=%b exp all 0",
                     gnt, done_ack, ap_start, ap_continue, busy, timeout_err);
        end
        n_checks++;
        if (txn_count !== '0 || last_latency !== '0) begin
            n_errors++;
            $display("FAIL reset_counts: got txn=%0d lat=%0d exp 0 0", txn_count, last_latency);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || ap_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b start=%b exp 0 0", busy, ap_start);
        end
        m_rr = 0; m_txn = 0;
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] g, av, eg;
        int sc, ac, ct, w;
        bit ia;
        int ack_cnt[NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
        for (int n = 0; n < 8; n++) begin
            w = pick(4'b1111, m_rr);
            exp_q.push_back(onehot_of(w));
            do_inv(4'b1111, 1, 2, 1'b0, 1'b0, g, sc, av, ac, ct, ia);
            eg = exp_q.pop_front();
            n_checks++;
            if (g !== eg) begin
                n_errors++;
                $display("FAIL fair_gnt[%0d]: got %b exp %b", n, g, eg);
            end
            n_checks++;
            if (!ia) begin
                n_errors++;
                $display("FAIL fair_idle_gap[%0d]: got busy after DONE exp idle", n);
            end
            for (int i = 0; i < NUM_REQ; i++) if (av[i]) ack_cnt[i] += ac;
            m_rr = (w + 1) % NUM_REQ;
            m_txn++;
        end
        n_checks++;
        if (txn_count !== CNT_W'(m_txn)) begin
            n_errors++;
            $display("FAIL fair_txn: got %0d exp %0d", txn_count, m_txn);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++;
            if (ack_cnt[i] != 2) begin
                n_errors++;
                $display("FAIL fair_acks[%0d]: got %0d exp 2", i, ack_cnt[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] g, av, eg;
        int sc, ac, ct, w;
        bit ia;
        w = pick(4'b0010, m_rr);
        eg = onehot_of(w);
        do_inv(4'b0010, 2, 5, 1'b0, 1'b0, g, sc, av, ac, ct, ia);
        m_rr = (w + 1) % NUM_REQ;
        m_txn++;
        n_checks++;
        if (g !== eg) begin
            n_errors++;
            $display("FAIL single_gnt: got %b exp %b", g, eg);
        end
        n_checks++;
        if (sc != 3) begin
            n_errors++;
            $display("FAIL single_start_len: got %0d exp 3", sc);
        end
        n_checks++;
        if (last_latency !== CNT_W'(2 + 1 + 5)) begin
            n_errors++;
            $display("FAIL single_latency: got %0d exp 8", last_latency);
        end
        n_checks++;
        if (txn_count !== CNT_W'(m_txn)) begin
            n_errors++;
            $display("FAIL single_txn: got %0d exp %0d", txn_count, m_txn);
        end
        n_checks++;
        if (av !== eg || ac != 1) begin
            n_errors++;
            $display("FAIL single_ack: got %b x%0d exp %b x1", av, ac, eg);
        end
    endtask

    task automatic test_same_cycle();
        logic [NUM_REQ-1:0] g, av;
        int sc, ac, ct, w;
        bit ia;
        w = pick(4'b0100, m_rr);
        do_inv(4'b0100, 0, 1, 1'b1, 1'b0, g, sc, av, ac, ct, ia);
        m_rr = (w + 1) % NUM_REQ;
        m_txn++;
        n_checks++;
        if (sc != 1 || last_latency !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL same_cycle: got start_len=%0d lat=%0d exp 1 1", sc, last_latency);
        end
        n_checks++;
        if (ct != 1 || ac != 1) begin
            n_errors++;
            $display("FAIL same_cycle_pulses: got cont=%0d ack=%0d exp 1 1", ct, ac);
        end
    endtask

    task automatic test_owner_drop();
        logic [NUM_REQ-1:0] g, av, eg;
        int sc, ac, ct, w;
        bit ia;
        w = pick(4'b0001, m_rr);
        do_inv(4'b0001, 1, 3, 1'b0, 1'b1, g, sc, av, ac, ct, ia);
        m_rr = (w + 1) % NUM_REQ;
        m_txn++;
        n_checks++;
        if (av !== 4'b0001 || ac != 1) begin
            n_errors++;
            $display("FAIL drop_ack: got %b x%0d exp 0001 x1", av, ac);
        end
        w = pick(4'b1001, m_rr);
        eg = onehot_of(w);
        do_inv(4'b1001, 0, 2, 1'b0, 1'b0, g, sc, av, ac, ct, ia);
        m_rr = (w + 1) % NUM_REQ;
        m_txn++;
        n_checks++;
        if (g !== eg) begin
            n_errors++;
            $display("FAIL drop_next_gnt: got %b exp %b", g, eg);
        end
    endtask

    task automatic test_idle_noise();
        int bad;
        bad = 0;
        req = '0;
        ap_done = 1'b1; ap_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (busy || done_ack != '0 || ap_continue) bad++;
        end
        ap_done = 1'b0; ap_ready = 1'b0;
        n_checks++;
        if (bad != 0 || txn_count !== CNT_W'(m_txn)) begin
            n_errors++;
            $display("FAIL idle_done_ignored: got bad=%0d txn=%0d exp 0 %0d", bad, txn_count, m_txn);
        end
    endtask

    task automatic test_watchdog();
        int k, w;
        logic e16, e17;
        logic [NUM_REQ-1:0] eg;
        e16 = 1'bx; e17 = 1'bx;
        w = pick(4'b0010, m_rr);
        eg = onehot_of(w);
        req = 4'b0010;
        clr_err = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 20; cyc++) begin
            @(negedge clock);
            if (busy) begin
                k++;
                req = '0;
                ap_ready = (k == 2);
                if (k == 16) e16 = timeout_err;
                if (k == 17) begin
                    e17 = timeout_err;
                    clr_err = 1'b0;
                end
            end
        end
        ap_ready = 1'b0;
        n_checks++;
        if (e16 !== 1'b0 || e17 !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_rise: got @16=%b @17=%b exp 0 1", e16, e17);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || ap_continue !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_sticky: got err=%b cont=%b busy=%b exp 1 0 1", timeout_err, ap_continue, busy);
        end
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_clear: got %b exp 0", timeout_err);
        end
        ap_done = 1'b1;
        @(negedge clock);
        n_checks++;
        if (ap_continue !== 1'b1 || done_ack !== eg) begin
            n_errors++;
            $display("FAIL wdog_late_done: got cont=%b ack=%b exp 1 %b", ap_continue, done_ack, eg);
        end
        ap_done = 1'b0;
        @(negedge clock);
        m_rr = (w + 1) % NUM_REQ;
        m_txn++;
        n_checks++;
        if (txn_count !== CNT_W'(m_txn) || last_latency !== CNT_W'(21) || timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wdog_complete: got txn=%0d lat=%0d err=%b exp %0d 21 0",
                     txn_count, last_latency, timeout_err, m_txn);
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] g, av, eg, rq;
        int sc, ac, ct, w, rdy, run, elat;
        bit ia, same;
        for (int n = 0; n < 24; n++) begin
            rq   = NUM_REQ'($urandom_range(1, 15));
            rdy  = $urandom_range(0, 3);
            run  = $urandom_range(1, 6);
            same = ($urandom_range(0, 3) == 0);
            w    = pick(rq, m_rr);
            eg   = onehot_of(w);
            elat = same ? rdy + 1 : rdy + 1 + run;
            do_inv(rq, rdy, run, same, 1'b0, g, sc, av, ac, ct, ia);
            m_rr = (w + 1) % NUM_REQ;
            m_txn++;
            n_checks++;
            if (g !== eg || av !== eg || ac != 1 || ct != 1) begin
                n_errors++;
                $display("FAIL rand_gnt[%0d]: got gnt=%b ack=%b x%0d cont=%0d exp %b %b x1 1",
                         n, g, av, ac, ct, eg, eg);
            end
            n_checks++;
            if (last_latency !== CNT_W'(elat) || txn_count !== CNT_W'(m_txn) || sc != rdy + 1) begin
                n_errors++;
                $display("FAIL rand_stats[%0d]: got lat=%0d txn=%0d start=%0d exp %0d %0d %0d",
                         n, last_latency, txn_count, sc, elat, m_txn, rdy + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [NUM_REQ-1:0] g, av;
        int sc, ac, ct;
        bit ia, found;
        found = 1'b0;
        req = 4'b0110;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clock);
            if (ap_start) found = 1'b1;
        end
        ap_ready = 1'b1;
        @(negedge clock);
        ap_ready = 1'b0;
        req = '0;
        n_checks++;
        if (!(busy && !ap_start && !ap_continue)) begin
            n_errors++;
            $display("FAIL areset_in_run: got busy=%b start=%b cont=%b exp 1 0 0", busy, ap_start, ap_continue);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({gnt, done_ack, ap_start, ap_continue, busy, timeout_err} !== '0 ||
            txn_count !== '0 || last_latency !== '0) begin
            n_errors++;
            $display("FAIL areset_outputs: got gnt=%b busy=%b txn=%0d lat=%0d exp 0 0 0 0",
                     gnt, busy, txn_count, last_latency);
        end
        @(negedge clock);
        reset = 1'b0;
        m_rr = 0; m_txn = 0;
        do_inv(4'b1111, 1, 1, 1'b0, 1'b0, g, sc, av, ac, ct, ia);
        m_rr = 1; m_txn++;
        n_checks++;
        if (g !== 4'b0001 || txn_count !== CNT_W'(m_txn)) begin
            n_errors++;
            $display("FAIL areset_rr_ptr: got gnt=%b txn=%0d exp 0001 %0d", g, txn_count, m_txn);
        end
        do_inv(4'b1000, 0, 2, 1'b0, 1'b0, g, sc, av, ac, ct, ia);
        m_rr = 0; m_txn++;
        n_checks++;
        if (g !== 4'b1000 || av !== 4'b1000) begin
            n_errors++;
            $display("FAIL areset_after: got gnt=%b ack=%b exp 1000 1000", g, av);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (onehot_viol != 0 || ack_viol != 0 || gnt_move != 0) begin
            n_errors++;
            $display("FAIL invariants: got onehot=%0d ack=%0d gnt_move=%0d exp 0 0 0",
                     onehot_viol, ack_viol, gnt_move);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_same_cycle();
        test_owner_drop();
        test_idle_noise();
        test_watchdog();
        test_random();
        test_async_reset();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
